// File: rtl/sram_word_controller.sv
// sram_word_controller
//   Replaces the single-cycle data memory behind the MEM stage with an external 16-bit
//   asynchronous SRAM. Each 32-bit word access becomes two half-word accesses (low half
//   first), each held on the bus for WAIT_CYCLES cycles. While an access is in flight,
//   ready is low so the top level can freeze the whole pipeline.
//
//   Optional build macro: SRAM_LAST_READ_HIT_EN. When defined, the controller remembers
//   the address of the last completed read. A repeated read of that word completes in
//   the request cycle without touching the SRAM.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   rd_en, wr_en        word read / write request from the MEM stage
//   address             byte address (ALU result)
//   write_data          store data
//   read_data           registered load data, valid once the read completes
//   ready               0 means the pipeline must freeze
//   SRAM_DQ             bidirectional SRAM data bus
//   SRAM_ADDR           SRAM half-word address
//   SRAM_*_N            active-low SRAM strobes
module sram_word_controller #(
    parameter int unsigned SRAM_ADDR_WIDTH = 18,
    parameter int unsigned WAIT_CYCLES     = 3,
    parameter int unsigned MEM_BASE        = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_en,
    input  logic                       wr_en,
    input  logic [31:0]                address,
    input  logic [31:0]                write_data,
    output logic [31:0]                read_data,
    output logic                       ready,
    inout  wire  [15:0]                SRAM_DQ,
    output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
    output logic                       SRAM_WE_N,
    output logic                       SRAM_OE_N,
    output logic                       SRAM_CE_N,
    output logic                       SRAM_UB_N,
    output logic                       SRAM_LB_N
);

    localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e                     state_q, state_d;
    logic [CntW-1:0]            cnt_q;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q;
    logic [31:0]                data_q;
    logic                       is_wr_q;
    logic [31:0]                read_data_q;

    // Word index scaled to half-words: ((address - MEM_BASE) >> 2) << 1, truncated.
    logic [31:0]                offset;
    logic [SRAM_ADDR_WIDTH-1:0] waddr;
    logic                       unused_offset;
    assign offset        = address - 32'(MEM_BASE);
    assign waddr         = {offset[SRAM_ADDR_WIDTH:2], 1'b0};
    assign unused_offset = ^{offset[31:SRAM_ADDR_WIDTH+1], offset[1:0]};

    logic in_idle, in_phase, last, hit, start;
    assign in_idle  = (state_q == StIdle);
    assign in_phase = (state_q == StLow) || (state_q == StHigh);
    assign last     = (cnt_q == CntLast);

`ifdef SRAM_LAST_READ_HIT_EN
    logic [SRAM_ADDR_WIDTH-1:0] tag_q;
    logic                       tag_valid_q;

    assign hit = rd_en && !wr_en && tag_valid_q && (tag_q == waddr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
        end else if (in_idle && wr_en) begin
            tag_valid_q <= 1'b0;
        end else if (state_q == StHigh && last && !is_wr_q) begin
            // The high half sits at an odd address; clearing bit 0 recovers the word base.
            tag_q       <= {sram_addr_q[SRAM_ADDR_WIDTH-1:1], 1'b0};
            tag_valid_q <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    assign start = (rd_en || wr_en) && !hit;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StLow;
            StLow:  if (last)  state_d = StHigh;
            StHigh: if (last)  state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: latched request, wait counter, SRAM address and read capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            sram_addr_q <= '0;
            data_q      <= '0;
            is_wr_q     <= 1'b0;
            read_data_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (start) begin
                        sram_addr_q <= waddr;
                        data_q      <= write_data;
                        is_wr_q     <= wr_en;
                    end
                end
                StLow: begin
                    if (last) begin
                        cnt_q       <= '0;
                        sram_addr_q <= sram_addr_q + 1'b1;
                        if (!is_wr_q) read_data_q[15:0] <= SRAM_DQ;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHigh: begin
                    if (last) begin
                        cnt_q <= '0;
                        if (!is_wr_q) read_data_q[31:16] <= SRAM_DQ;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: cnt_q <= '0;
                default: cnt_q <= '0;
            endcase
        end
    end

    // Outputs
    logic        dq_oe;
    logic [15:0] dq_out;

    always_comb begin
        ready     = (in_idle && !start) || (state_q == StDone);
        SRAM_CE_N = !in_phase;
        SRAM_UB_N = !in_phase;
        SRAM_LB_N = !in_phase;
        SRAM_OE_N = !(in_phase && !is_wr_q);
        // WE_N rises one cycle before the phase ends so data is held past the write edge.
        SRAM_WE_N = !(in_phase && is_wr_q && !last);
        dq_oe     = in_phase && is_wr_q;
        dq_out    = (state_q == StHigh) ? data_q[31:16] : data_q[15:0];
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_ADDR = sram_addr_q;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_word_controller.sv
module tb_sram_word_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_word_controller dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (we_n),
        .SRAM_OE_N  (oe_n),
        .SRAM_CE_N  (ce_n),
        .SRAM_UB_N  (ub_n),
        .SRAM_LB_N  (lb_n)
    );

    // SRAM model: writes on clock edges while selected with WE_N low, drives reads when
    // OE_N is low. tb_drive puts a marker on an otherwise idle bus to prove the DUT
    // released it.
    logic [15:0] mem [0:63];
    logic        preload = 1'b1;
    logic        tb_drive = 1'b0;

    always @(posedge clk) begin
        if (preload) begin
            mem[0] <= 16'h0000;
            mem[1] <= 16'h0000;
            mem[4] <= 16'h5678;
            mem[5] <= 16'h1234;
        end else if (!ce_n && !we_n) begin
            mem[sram_addr[5:0]] <= sram_dq;
        end
    end

    assign sram_dq = (!oe_n && !ce_n) ? mem[sram_addr[5:0]] :
                     tb_drive         ? 16'h3C3C : 16'hzzzz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        ce;
        logic        we;
        logic        oe;
        int          exp_addr;   // -1: not checked
        int          exp_dq;     // -1: not checked
        longint      exp_rdata;  // -1: not checked
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r, logic w, logic [31:0] a, logic [31:0] d,
                                logic rdy, logic ce, logic we, logic oe,
                                int ea, int edq, longint erd);
        vec_t v;
        v.name = n; v.rd = r; v.wr = w; v.addr = a; v.wdata = d;
        v.rdy = rdy; v.ce = ce; v.we = we; v.oe = oe;
        v.exp_addr = ea; v.exp_dq = edq; v.exp_rdata = erd;
        return v;
    endfunction

    // One word access starting in IDLE; lat is the first cycle with ready=1 (-1 on timeout).
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output bit saw_oe);
        @(posedge clk); #1;
        rd_en = r; wr_en = w; address = a; write_data = d;
        lat = -1;
        saw_oe = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!oe_n) saw_oe = 1'b1;
            if (ready) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
            rd_en = 1'b0; wr_en = 1'b0;
        end
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  saw_oe;

        // Reset with no request
        tb_drive = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_strobes", {we_n, oe_n, ce_n, ub_n, lb_n}, 5'b11111);
        check("rst_dq_released", sram_dq, 16'h3C3C);
        check("rst_read_data", read_data, 0);
        check("rst_sram_addr", sram_addr, 0);
        preload = 1'b0;
        tb_drive = 1'b0;
        rst = 1'b1;

        // Write 0xDEADBEEF to 1024
        vecs.push_back(mk("w0", 0, 1, 1024, 32'hDEADBEEF, 0, 1, 1, 1, -1, -1, -1));
        vecs.push_back(mk("w1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 'hBEEF, -1));
        vecs.push_back(mk("w2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 'hBEEF, -1));
        vecs.push_back(mk("w3", 0, 0, 0, 0, 0, 0, 1, 1, 0, 'hBEEF, -1));
        vecs.push_back(mk("w4", 0, 0, 0, 0, 0, 0, 0, 1, 1, 'hDEAD, -1));
        vecs.push_back(mk("w5", 0, 0, 0, 0, 0, 0, 0, 1, 1, 'hDEAD, -1));
        vecs.push_back(mk("w6", 0, 0, 0, 0, 0, 0, 1, 1, 1, 'hDEAD, -1));
        vecs.push_back(mk("w7", 0, 0, 0, 0, 1, 1, 1, 1, -1, -1, 0));
        // Read 1032 -> half-words 4, 5
        vecs.push_back(mk("r0", 1, 0, 1032, 0, 0, 1, 1, 1, -1, -1, -1));
        vecs.push_back(mk("r1", 0, 0, 0, 0, 0, 0, 1, 0, 4, 'h5678, -1));
        vecs.push_back(mk("r2", 0, 0, 0, 0, 0, 0, 1, 0, 4, 'h5678, -1));
        vecs.push_back(mk("r3", 0, 0, 0, 0, 0, 0, 1, 0, 4, 'h5678, -1));
        vecs.push_back(mk("r4", 0, 0, 0, 0, 0, 0, 1, 0, 5, 'h1234, 'h00005678));
        vecs.push_back(mk("r5", 0, 0, 0, 0, 0, 0, 1, 0, 5, 'h1234, -1));
        vecs.push_back(mk("r6", 0, 0, 0, 0, 0, 0, 1, 0, 5, 'h1234, -1));
        vecs.push_back(mk("r7", 0, 0, 0, 0, 1, 1, 1, 1, -1, -1, 'h12345678));
        // Read and write together: write wins, read_data untouched
        vecs.push_back(mk("rw0", 1, 1, 1024, 32'hA5A5A5A5, 0, 1, 1, 1, -1, -1, -1));
        vecs.push_back(mk("rw1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 'hA5A5, -1));
        vecs.push_back(mk("rw2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 'hA5A5, -1));
        vecs.push_back(mk("rw3", 0, 0, 0, 0, 0, 0, 1, 1, 0, 'hA5A5, -1));
        vecs.push_back(mk("rw4", 0, 0, 0, 0, 0, 0, 0, 1, 1, 'hA5A5, -1));
        vecs.push_back(mk("rw5", 0, 0, 0, 0, 0, 0, 0, 1, 1, 'hA5A5, -1));
        vecs.push_back(mk("rw6", 0, 0, 0, 0, 0, 0, 1, 1, 1, 'hA5A5, -1));
        vecs.push_back(mk("rw7", 0, 0, 0, 0, 1, 1, 1, 1, -1, -1, 'h12345678));

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            rd_en = vecs[i].rd; wr_en = vecs[i].wr;
            address = vecs[i].addr; write_data = vecs[i].wdata;
            @(negedge clk);
            check({vecs[i].name, "_ready"}, ready, vecs[i].rdy);
            check({vecs[i].name, "_ce_ub_lb"}, {ce_n, ub_n, lb_n}, {3{vecs[i].ce}});
            check({vecs[i].name, "_we_n"}, we_n, vecs[i].we);
            check({vecs[i].name, "_oe_n"}, oe_n, vecs[i].oe);
            if (vecs[i].exp_addr >= 0)
                check({vecs[i].name, "_addr"}, 64'(sram_addr), 64'(vecs[i].exp_addr));
            if (vecs[i].exp_dq >= 0)
                check({vecs[i].name, "_dq"}, 64'(sram_dq), 64'(vecs[i].exp_dq));
            if (vecs[i].exp_rdata >= 0)
                check({vecs[i].name, "_rdata"}, 64'(read_data), 64'(vecs[i].exp_rdata));
        end
        rd_en = 1'b0; wr_en = 1'b0;
        check("mem0_after_rw", mem[0], 16'hA5A5);
        check("mem1_after_rw", mem[1], 16'hA5A5);

        // Repeated read: hit when the last-read tag is built in, full access otherwise
        access(1, 0, 1032, 0, lat, saw_oe);
        check("reread1_lat", lat, 7);
        check("reread1_rdata", read_data, 32'h12345678);
        access(1, 0, 1032, 0, lat, saw_oe);
`ifdef SRAM_LAST_READ_HIT_EN
        check("reread2_lat", lat, 0);
        check("reread2_oe_seen", saw_oe, 0);
`else
        check("reread2_lat", lat, 7);
        check("reread2_oe_seen", saw_oe, 1);
`endif
        check("reread2_rdata", read_data, 32'h12345678);
        access(0, 1, 1024, 32'hCAFEF00D, lat, saw_oe);
        check("wr_cafe_lat", lat, 7);
        access(1, 0, 1032, 0, lat, saw_oe);
        check("read_after_wr_lat", lat, 7);
        check("read_after_wr_oe_seen", saw_oe, 1);
        check("mem0_cafe", mem[0], 16'hF00D);
        check("mem1_cafe", mem[1], 16'hCAFE);

        // Reset during the first cycle of the high half of a write
        @(posedge clk); #1;
        wr_en = 1'b1; address = 1024; write_data = 32'h11112222;
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_we_n", we_n, 0);
        rst = 1'b0;
        tb_drive = 1'b1;
        #1;
        check("midrst_strobes", {we_n, oe_n, ce_n, ub_n, lb_n}, 5'b11111);
        check("midrst_dq_released", sram_dq, 16'h3C3C);
        check("midrst_ready", ready, 1);
        check("midrst_rdata", read_data, 0);
        check("midrst_addr", sram_addr, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        tb_drive = 1'b0;
        @(negedge clk);
        check("post_rst_ready", ready, 1);
        check("post_rst_ce_n", ce_n, 1);
        check("midrst_mem0", mem[0], 16'h2222);
        check("midrst_mem1_kept", mem[1], 16'hCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
